// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: bundles the requester, response and ALU-side signals of the shared-ALU arbiter.
// Latency: none (wires only).
// Backpressure: reqN_ready only; responses and ALU results are never stalled.
// Modports: slave = arbiter view, master = environment view (requesters + ALU).
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int INST_W = 4
);
  // requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic [INST_W-1:0] req0_mode;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              resp0_valid;
  // requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic [INST_W-1:0] req1_mode;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              resp1_valid;
  // shared response payload
  logic [2*DATA_W-1:0] resp_data;
  logic                resp_err;
  // ALU side
  logic                alu_valid;
  logic [INST_W-1:0]   alu_mode;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic                alu_ready;
  logic [2*DATA_W-1:0] alu_data;

  modport slave (
    input  req0_valid, req0_mode, req0_a, req0_b,
    input  req1_valid, req1_mode, req1_a, req1_b,
    input  alu_ready, alu_data,
    output req0_ready, resp0_valid, req1_ready, resp1_valid,
    output resp_data, resp_err,
    output alu_valid, alu_mode, alu_a, alu_b
  );

  modport master (
    output req0_valid, req0_mode, req0_a, req0_b,
    output req1_valid, req1_mode, req1_a, req1_b,
    output alu_ready, alu_data,
    input  req0_ready, resp0_valid, req1_ready, resp1_valid,
    input  resp_data, resp_err,
    input  alu_valid, alu_mode, alu_a, alu_b
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one multi-cycle ALU between two requesters, one op in flight.
// Latency: accept edge E0 -> alu_valid E0..E1 -> respN_valid for one cycle starting the edge alu_ready is sampled.
// Backpressure: reqN_ready (combinational) only in IDLE; responses cannot be stalled by requesters.
// Ports: clk; rst (synchronous, active-high); bus (slave modport) carrying req0/req1 valid/ready/mode/a/b,
//        resp0/resp1 valid pulses sharing resp_data/resp_err, ALU issue alu_valid/mode/a/b and return alu_ready/alu_data.
module alu_share_arbiter #(
  parameter int DATA_W   = 32,
  parameter int INST_W   = 4,
  parameter int MAX_MODE = 10,
  parameter int TIMEOUT  = 40
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;          // requester with priority on the next grant
  logic                owner_q, owner_d;    // requester that owns the op in flight
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [INST_W-1:0]   alu_mode_q, alu_mode_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [2*DATA_W-1:0] resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;

  logic                gnt_id;
  logic                sel_valid;
  logic [INST_W-1:0]   sel_mode;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    alu_mode_d  = alu_mode_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    // The pointed-to requester wins if valid, otherwise the other one.
    if (rr_q == 1'b0) gnt_id = bus.req0_valid ? 1'b0 : 1'b1;
    else              gnt_id = bus.req1_valid ? 1'b1 : 1'b0;

    sel_valid = gnt_id ? bus.req1_valid : bus.req0_valid;
    sel_mode  = gnt_id ? bus.req1_mode  : bus.req0_mode;
    sel_a     = gnt_id ? bus.req1_a     : bus.req0_a;
    sel_b     = gnt_id ? bus.req1_b     : bus.req0_b;

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          owner_d = gnt_id;
          rr_d    = ~gnt_id;
          if (int'(sel_mode) <= MAX_MODE) begin
            // ALU operand registers only change on a real issue, so they
            // keep the previous op's values across illegal-mode rejects.
            alu_mode_d = sel_mode;
            alu_a_d    = sel_a;
            alu_b_d    = sel_b;
            state_d    = ISSUE;
          end else begin
            resp_data_d = '0;
            resp_err_d  = 1'b1;
            state_d     = RESP;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.alu_ready) begin
          resp_data_d = bus.alu_data;
          resp_err_d  = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      alu_mode_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      alu_mode_q  <= alu_mode_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign bus.req0_ready  = (state_q == IDLE) && bus.req0_valid && (gnt_id == 1'b0);
  assign bus.req1_ready  = (state_q == IDLE) && bus.req1_valid && (gnt_id == 1'b1);
  assign bus.resp0_valid = (state_q == RESP) && (owner_q == 1'b0);
  assign bus.resp1_valid = (state_q == RESP) && (owner_q == 1'b1);
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.alu_valid   = (state_q == ISSUE);
  assign bus.alu_mode    = alu_mode_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed tests of the shared-ALU arbiter against a small ALU model.
// Latency: ALU model asserts ready mdl_lat cycles after it sees alu_valid (0 = never).
// Backpressure: none modelled; requesters drop valid after their accept edge.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_arbiter_if bif();

  alu_share_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // ALU model: mode 9 multiplies, everything else adds.
  int          mdl_lat   = 1;
  int          mdl_cnt   = 0;
  logic        mdl_rdy   = 1'b0;
  logic        extra_rdy = 1'b0;
  logic [63:0] mdl_res   = 64'd0;

  always @(negedge clk) begin
    if (bif.alu_valid) begin
      mdl_cnt <= mdl_lat;
      mdl_rdy <= 1'b0;
      mdl_res <= (bif.alu_mode == 4'd9) ? ({32'd0, bif.alu_a} * {32'd0, bif.alu_b})
                                        : ({32'd0, bif.alu_a} + {32'd0, bif.alu_b});
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      mdl_rdy <= (mdl_cnt == 1);
    end else begin
      mdl_rdy <= 1'b0;
    end
  end

  assign bif.alu_ready = mdl_rdy | extra_rdy;
  assign bif.alu_data  = mdl_res;

  task automatic idle_inputs();
    bif.req0_valid = 1'b0; bif.req0_mode = 4'd0; bif.req0_a = 32'd0; bif.req0_b = 32'd0;
    bif.req1_valid = 1'b0; bif.req1_mode = 4'd0; bif.req1_a = 32'd0; bif.req1_b = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    n_chk++; if ({bif.alu_valid, bif.resp0_valid, bif.resp1_valid, bif.resp_err} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {bif.alu_valid, bif.resp0_valid, bif.resp1_valid, bif.resp_err}); end
    n_chk++; if (bif.resp_data !== 64'd0) begin n_fail++; $display("FAIL reset_data got=%0h exp=0", bif.resp_data); end
    n_chk++; if ({bif.alu_mode, bif.alu_a, bif.alu_b} !== 68'd0) begin n_fail++; $display("FAIL reset_alu_bus got=%0h exp=0", {bif.alu_mode, bif.alu_a, bif.alu_b}); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if ({bif.req0_ready, bif.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", {bif.req0_ready, bif.req1_ready}); end
  endtask

  task automatic test_short();
    mdl_lat = 1;
    bif.req0_valid = 1'b1; bif.req0_mode = 4'd0; bif.req0_a = 32'd5; bif.req0_b = 32'd3;
    #1;
    n_chk++; if ({bif.req0_ready, bif.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL short_grant got=%b exp=10", {bif.req0_ready, bif.req1_ready}); end
    @(posedge clk);                       // E0
    @(negedge clk); bif.req0_valid = 1'b0; // E0..E1
    n_chk++; if (bif.alu_valid !== 1'b1) begin n_fail++; $display("FAIL short_issue got=%b exp=1", bif.alu_valid); end
    n_chk++; if ({bif.alu_mode, bif.alu_a, bif.alu_b} !== {4'd0, 32'd5, 32'd3}) begin n_fail++; $display("FAIL short_operands got=%0h exp=%0h", {bif.alu_mode, bif.alu_a, bif.alu_b}, {4'd0, 32'd5, 32'd3}); end
    @(negedge clk);                       // E1..E2
    n_chk++; if ({bif.alu_valid, bif.resp0_valid} !== 2'b00) begin n_fail++; $display("FAIL short_e1 got=%b exp=00", {bif.alu_valid, bif.resp0_valid}); end
    @(negedge clk);                       // E2..E3
    n_chk++; if ({bif.resp0_valid, bif.resp1_valid, bif.resp_err} !== 3'b100) begin n_fail++; $display("FAIL short_resp got=%b exp=100", {bif.resp0_valid, bif.resp1_valid, bif.resp_err}); end
    n_chk++; if (bif.resp_data !== 64'd8) begin n_fail++; $display("FAIL short_data got=%0d exp=8", bif.resp_data); end
    @(negedge clk);                       // E3..E4
    n_chk++; if (bif.resp0_valid !== 1'b0 || bif.resp_data !== 64'd8) begin n_fail++; $display("FAIL short_hold got=%b/%0d exp=0/8", bif.resp0_valid, bif.resp_data); end
  endtask

  task automatic test_fairness();
    int   q0[$];
    int   q1[$];
    int   n0;
    int   n1;
    int   g;
    int   last;
    int   got;
    logic r0;
    logic r1;
    n0 = 0; n1 = 0; g = 0; last = -100; got = 0;
    @(negedge clk); rst = 1'b1; idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0; mdl_lat = 1;
    bif.req0_valid = 1'b1; bif.req0_mode = 4'd0; bif.req0_a = 32'd10;  bif.req0_b = 32'd1;
    bif.req1_valid = 1'b1; bif.req1_mode = 4'd0; bif.req1_a = 32'd100; bif.req1_b = 32'd2;
    for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
      #1;
      r0 = bif.req0_ready;
      r1 = bif.req1_ready;
      if (bif.resp0_valid) begin
        got++;
        n_chk++; if (q0.size() == 0 || bif.resp_data !== 64'(q0[0]) || bif.resp_err !== 1'b0) begin n_fail++; $display("FAIL fair_resp0 got=%0d err=%b exp=%0d", bif.resp_data, bif.resp_err, (q0.size() != 0) ? q0[0] : -1); end
        if (q0.size() != 0) void'(q0.pop_front());
      end
      if (bif.resp1_valid) begin
        got++;
        n_chk++; if (q1.size() == 0 || bif.resp_data !== 64'(q1[0]) || bif.resp_err !== 1'b0) begin n_fail++; $display("FAIL fair_resp1 got=%0d err=%b exp=%0d", bif.resp_data, bif.resp_err, (q1.size() != 0) ? q1[0] : -1); end
        if (q1.size() != 0) void'(q1.pop_front());
      end
      if (r0 || r1) begin
        n_chk++; if ({r0, r1} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL fair_grant%0d got=%b exp=%b", g, {r0, r1}, (g % 2 == 0) ? 2'b10 : 2'b01); end
        if (last >= 0) begin
          n_chk++; if (cyc - last != 4) begin n_fail++; $display("FAIL fair_spacing got=%0d exp=4", cyc - last); end
        end
        last = cyc;
        g++;
        if (r0) begin q0.push_back(11 + n0); n0++; end
        else    begin q1.push_back(102 + n1); n1++; end
      end
      @(negedge clk);
      if (r0) begin if (n0 < 3) bif.req0_a = 32'(10 + n0); else bif.req0_valid = 1'b0; end
      if (r1) begin if (n1 < 3) bif.req1_a = 32'(100 + n1); else bif.req1_valid = 1'b0; end
    end
    n_chk++; if (got != 6 || g != 6) begin n_fail++; $display("FAIL fair_count got=%0d resp %0d grants exp=6/6", got, g); end
  endtask

  task automatic test_long();
    logic bad;
    @(negedge clk);
    mdl_lat = 33;
    bif.req1_valid = 1'b1; bif.req1_mode = 4'd9; bif.req1_a = 32'd7; bif.req1_b = 32'd6;
    #1;
    n_chk++; if (bif.req1_ready !== 1'b1) begin n_fail++; $display("FAIL long_grant got=%b exp=1", bif.req1_ready); end
    @(posedge clk);
    @(negedge clk);                       // k=0
    bif.req1_valid = 1'b0;
    bif.req0_valid = 1'b1; bif.req0_mode = 4'd0; bif.req0_a = 32'd1; bif.req0_b = 32'd1;
    n_chk++; if (bif.alu_valid !== 1'b1 || bif.alu_mode !== 4'd9) begin n_fail++; $display("FAIL long_issue got=%b/%0d exp=1/9", bif.alu_valid, bif.alu_mode); end
    bad = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 5) mdl_lat = 1;
      if (bif.resp0_valid || bif.resp1_valid || bif.req0_ready || bif.alu_valid) bad = 1'b1;
    end
    n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL long_quiet got=%b exp=0", bad); end
    @(negedge clk);                       // k=34
    n_chk++; if ({bif.resp1_valid, bif.resp0_valid, bif.resp_err} !== 3'b100) begin n_fail++; $display("FAIL long_resp got=%b exp=100", {bif.resp1_valid, bif.resp0_valid, bif.resp_err}); end
    n_chk++; if (bif.resp_data !== 64'd42) begin n_fail++; $display("FAIL long_data got=%0d exp=42", bif.resp_data); end
    @(negedge clk);                       // k=35
    n_chk++; if (bif.req0_ready !== 1'b1) begin n_fail++; $display("FAIL long_next_grant got=%b exp=1", bif.req0_ready); end
    @(posedge clk);
    @(negedge clk); bif.req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (bif.resp0_valid !== 1'b1 || bif.resp_data !== 64'd2) begin n_fail++; $display("FAIL long_next_resp got=%b/%0d exp=1/2", bif.resp0_valid, bif.resp_data); end
  endtask

  task automatic test_timeout();
    logic bad;
    @(negedge clk);
    mdl_lat = 0;
    bif.req0_valid = 1'b1; bif.req0_mode = 4'd10; bif.req0_a = 32'd3; bif.req0_b = 32'd4;
    #1;
    n_chk++; if (bif.req0_ready !== 1'b1) begin n_fail++; $display("FAIL to_grant got=%b exp=1", bif.req0_ready); end
    @(posedge clk);
    @(negedge clk); bif.req0_valid = 1'b0; // k=0
    n_chk++; if (bif.alu_valid !== 1'b1) begin n_fail++; $display("FAIL to_issue got=%b exp=1", bif.alu_valid); end
    bad = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (bif.resp0_valid || bif.resp1_valid) bad = 1'b1;
    end
    n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL to_early_resp got=%b exp=0", bad); end
    @(negedge clk);                       // k=42
    n_chk++; if ({bif.resp0_valid, bif.resp_err} !== 2'b11 || bif.resp_data !== 64'd0) begin n_fail++; $display("FAIL to_resp got=%b/%0h exp=11/0", {bif.resp0_valid, bif.resp_err}, bif.resp_data); end
    @(negedge clk);                       // k=43: stale ready while idle
    extra_rdy = 1'b1; mdl_lat = 1;
    n_chk++; if (bif.resp_err !== 1'b1 || bif.resp0_valid !== 1'b0) begin n_fail++; $display("FAIL to_err_hold got=%b/%b exp=1/0", bif.resp_err, bif.resp0_valid); end
    @(negedge clk);                       // k=44
    extra_rdy = 1'b0;
    n_chk++; if ({bif.resp0_valid, bif.resp1_valid, bif.alu_valid} !== 3'b000) begin n_fail++; $display("FAIL to_stale got=%b exp=000", {bif.resp0_valid, bif.resp1_valid, bif.alu_valid}); end
    bif.req0_valid = 1'b1; bif.req0_mode = 4'd1; bif.req0_a = 32'd20; bif.req0_b = 32'd2;
    @(posedge clk);
    @(negedge clk); bif.req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({bif.resp0_valid, bif.resp_err} !== 2'b10 || bif.resp_data !== 64'd22) begin n_fail++; $display("FAIL to_recover got=%b/%0d exp=10/22", {bif.resp0_valid, bif.resp_err}, bif.resp_data); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    bif.req1_valid = 1'b1; bif.req1_mode = 4'd12; bif.req1_a = 32'd9; bif.req1_b = 32'd9;
    #1;
    n_chk++; if (bif.req1_ready !== 1'b1) begin n_fail++; $display("FAIL ill_grant got=%b exp=1", bif.req1_ready); end
    @(posedge clk);
    @(negedge clk); bif.req1_valid = 1'b0;
    n_chk++; if ({bif.alu_valid, bif.resp1_valid, bif.resp_err} !== 3'b011 || bif.resp_data !== 64'd0) begin n_fail++; $display("FAIL ill_resp got=%b/%0h exp=011/0", {bif.alu_valid, bif.resp1_valid, bif.resp_err}, bif.resp_data); end
    n_chk++; if (bif.alu_a !== 32'd20) begin n_fail++; $display("FAIL ill_alu_hold got=%0d exp=20", bif.alu_a); end
    @(negedge clk);
    n_chk++; if ({bif.alu_valid, bif.resp1_valid} !== 2'b00) begin n_fail++; $display("FAIL ill_after got=%b exp=00", {bif.alu_valid, bif.resp1_valid}); end
  endtask

  task automatic test_reset_mid_wait();
    logic bad;
    @(negedge clk);
    mdl_lat = 33;
    bif.req1_valid = 1'b1; bif.req1_mode = 4'd9; bif.req1_a = 32'd7; bif.req1_b = 32'd6;
    @(posedge clk);
    @(negedge clk); bif.req1_valid = 1'b0; // k=0
    n_chk++; if (bif.alu_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_issue got=%b exp=1", bif.alu_valid); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);                       // k=5, one reset edge seen
    n_chk++; if ({bif.alu_valid, bif.resp0_valid, bif.resp1_valid, bif.resp_err} !== 4'b0) begin n_fail++; $display("FAIL rmid_ctrl got=%b exp=0000", {bif.alu_valid, bif.resp0_valid, bif.resp1_valid, bif.resp_err}); end
    n_chk++; if ({bif.alu_mode, bif.alu_a, bif.alu_b} !== 68'd0 || bif.resp_data !== 64'd0) begin n_fail++; $display("FAIL rmid_bus got=%0h/%0h exp=0/0", {bif.alu_mode, bif.alu_a, bif.alu_b}, bif.resp_data); end
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 6; k <= 40; k++) begin
      @(negedge clk);
      if (k == 36) mdl_lat = 1;
      if (bif.resp0_valid || bif.resp1_valid || bif.alu_valid) bad = 1'b1;
    end
    n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rmid_silent got=%b exp=0", bad); end
    bif.req0_valid = 1'b1; bif.req0_mode = 4'd0; bif.req0_a = 32'd1; bif.req0_b = 32'd2;
    bif.req1_valid = 1'b1; bif.req1_mode = 4'd0; bif.req1_a = 32'd3; bif.req1_b = 32'd3;
    #1;
    n_chk++; if ({bif.req0_ready, bif.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL rmid_rr got=%b exp=10", {bif.req0_ready, bif.req1_ready}); end
    @(posedge clk);
    @(negedge clk); bif.req0_valid = 1'b0; bif.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({bif.resp0_valid, bif.resp_err} !== 2'b10 || bif.resp_data !== 64'd3) begin n_fail++; $display("FAIL rmid_next got=%b/%0d exp=10/3", {bif.resp0_valid, bif.resp_err}, bif.resp_data); end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_short();
    test_fairness();
    test_long();
    test_timeout();
    test_illegal();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one multi-cycle ALU (valid/ready/mode/in_A/in_B/out_data) between two requesters.
Arbitrates round-robin, issues one operation at a time, and waits for the ALU's ready (1 cycle for modes 0-8, 33 cycles for modes 9-10).
Routes the 64-bit result back to the requester that issued it.
Has a watchdog timeout and rejects illegal modes.

Parameters:
DATA_W, 32, operand width
INST_W, 4, mode width
MAX_MODE, 10, highest legal mode; larger modes are rejected
TIMEOUT, 40, max WAIT cycles before abort (must exceed 33)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted (combinational)
req0_mode  in  INST_W  requester 0 mode
req0_a  in  DATA_W  requester 0 operand A
req0_b  in  DATA_W  requester 0 operand B
resp0_valid  out  1  one-cycle result pulse for requester 0
req1_valid / req1_ready / req1_mode / req1_a / req1_b / resp1_valid  same as requester 0, for requester 1
resp_data  out  2*DATA_W  result, valid with respN_valid
resp_err  out  1  qualifies respN_valid: timeout or illegal mode
alu_valid  out  1  one-cycle issue pulse to ALU
alu_mode  out  INST_W  latched mode
alu_a  out  DATA_W  latched A
alu_b  out  DATA_W  latched B
alu_ready  in  1  ALU result valid
alu_data  in  2*DATA_W  ALU result

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset (sync, rst=1 at edge) forces:
  - IDLE, rr pointer = 0, wait counter = 0;
  - all outputs 0, including alu_valid, respN_valid, resp_data, resp_err, alu_mode/a/b.
  - Reset mid-operation aborts silently; no response is produced.
- IDLE, grant:
  - reqN_ready = reqN_valid && granted(N); only in IDLE, never both high.
  - Granted requester is rr pointer if it is valid, else the other one.
  - Requesters hold valid/mode/a/b stable until ready.
- IDLE, accept edge:
  - latch mode/a/b and the owner id; rr pointer = other requester.
  - Legal mode (<= MAX_MODE) -> ISSUE. Illegal mode -> RESP with err=1, data=0, ALU untouched.
- ISSUE:
  - alu_valid=1 for exactly one cycle; alu_mode/a/b driven from latches and held until next issue.
  - Next state is WAIT; counter cleared.
- WAIT:
  - alu_ready sampled each edge. If 1: capture alu_data -> RESP with err=0.
  - Else counter++; if counter reaches TIMEOUT -> RESP with err=1, data=0.
- RESP:
  - resp{owner}_valid=1 for one cycle with resp_data/resp_err; then IDLE.
  - No backpressure: requesters must accept.
- alu_ready outside WAIT is ignored. This covers stale ready after a reset or timeout.
- resp_data/resp_err hold their last value outside RESP.
- Latency from accept edge E0:
  - alu_valid high E0->E1.
  - Short op (ready E1->E2): respN_valid E2->E3.
  - Long op (ready 33 cycles after valid): respN_valid E34->E35.
- Throughput: next accept is no earlier than the edge after RESP (E4 for back-to-back short ops).
- Simultaneous valid after reset: requester 0 wins first, then strict alternation while both stay valid.

Test Plan:
- Short op: rst 2 cycles; req0 mode=0, A=5, B=3; ALU model returns 8 one cycle after valid -> alu_valid exactly 1 cycle at E0; resp0_valid at E2 with data=64'd8, err=0; resp1_valid stays 0.
- Fairness: req0 and req1 both held valid with 3 short ops each -> grants strictly alternate 0,1,0,1,0,1; every response goes to the issuing requester; accept edges 4 cycles apart.
- Long op: req1 mode=9, A=7, B=6; model ready 33 cycles after valid, data=42 -> resp1_valid at E34 with data=42; no accept in between even with req0 valid.
- Timeout: model never asserts ready; req0 mode=10 -> resp0_valid with err=1, data=0 at E0+TIMEOUT+2; a late alu_ready pulse is ignored; next request is served normally.
- Illegal mode: req1 mode=4'd12 -> alu_valid never rises; resp1_valid with err=1 on the edge after accept.
- Reset mid-WAIT: rst during a long op -> all outputs 0 next edge; no response; the ALU's later ready is ignored; the next req0 is granted (rr=0).
